// File: rtl/synth_top_if.sv
// synth_top_if: I2S master output bundle (mclk, lrck, sck, sdout)
interface synth_top_if;
    logic mclk;
    logic lrck;
    logic sck;
    logic sdout;
    modport master(output mclk, lrck, sck, sdout);
    modport slave(input mclk, lrck, sck, sdout);
endinterface

// File: rtl/synth_top.sv
// synth_top: triangle-wave phase oscillator streamed as 24-bit stereo I2S
module synth_top #(
    parameter logic [7:0] PHASE_INC = 8'd1
) (
    input  logic              clk,
    input  logic              rst,
    synth_top_if.master       i2s,
    output logic [7:0]        led,
    output logic [7:0]        phase,
    output logic [7:0]        s
);
    logic [9:0]  cnt;
    logic [4:0]  nk;
    logic [4:0]  idx;
    logic [23:0] w;
    logic        nxt;
    logic        sd;
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            cnt   <= '0;
            phase <= '0;
            sd    <= 1'b0;
        end else begin
            cnt <= cnt + 10'd1;
            if (&cnt) phase <= phase + PHASE_INC;
            if (&cnt[3:0]) sd <= nxt;
        end
    // nk is the slot being entered on this sck falling edge; the one-slot I2S delay puts W[23] in slot 1
    always_comb begin
        s   = phase[7] ? ~{phase[6:0], 1'b0} : {phase[6:0], 1'b0};
        w   = {s ^ 8'h80, 16'h0000};
        nk  = cnt[8:4] + 5'd1;
        idx = 5'd24 - nk;
        nxt = (nk != 5'd0 && nk <= 5'd24) ? w[idx] : 1'b0;
        led = s;
    end
    assign i2s.mclk  = cnt[1];
    assign i2s.sck   = cnt[3];
    assign i2s.lrck  = cnt[9];
    assign i2s.sdout = sd;
endmodule

// File: tb/tb_synth_top.sv
// tb_synth_top: directed checks of clock dividers, I2S framing, triangle and reset
module tb_synth_top;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;
    synth_top_if b1();
    synth_top_if b3();
    synth_top_if b64();
    synth_top_if b85();
    logic [7:0] led1, ph1, s1, led3, ph3, s3, led64, ph64, s64, led85, ph85, s85;
    synth_top u1(.clk(clk), .rst(rst), .i2s(b1), .led(led1), .phase(ph1), .s(s1));
    synth_top #(.PHASE_INC(8'd3)) u3(.clk(clk), .rst(rst), .i2s(b3), .led(led3), .phase(ph3), .s(s3));
    synth_top #(.PHASE_INC(8'd64)) u64(.clk(clk), .rst(rst), .i2s(b64), .led(led64), .phase(ph64), .s(s64));
    synth_top #(.PHASE_INC(8'd85)) u85(.clk(clk), .rst(rst), .i2s(b85), .led(led85), .phase(ph85), .s(s85));
    int nvec = 0;
    int nerr = 0;
    int n = 0;
    logic [31:0] l1, r1, l64;
    int bad, lr;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    // one frame starting at cnt==0; slot bits gathered at each sck rising edge
    task automatic frame(output logic [31:0] l, output logic [31:0] r, output logic [31:0] l6,
                         output int nbad, output int lrise);
        logic prev;
        logic [9:0] c;
        l = '0; r = '0; l6 = '0; nbad = 0; lrise = -1;
        for (int i = 1; i <= 1024; i++) begin
            prev = b1.sdout;
            @(negedge clk);
            n++;
            c = n[9:0];
            if (b1.mclk !== c[1] || b1.sck !== c[3] || b1.lrck !== c[9]) nbad++;
            if (c[3:0] != 4'd0 && b1.sdout !== prev) nbad++;
            if (lrise < 0 && b1.lrck === 1'b1) lrise = i;
            if (c[3:0] == 4'd8) begin
                if (c[9]) r[31 - int'(c[8:4])] = b1.sdout;
                else begin
                    l[31 - int'(c[8:4])]  = b1.sdout;
                    l6[31 - int'(c[8:4])] = b64.sdout;
                end
            end
        end
    endtask
    initial begin
        repeat (2) @(negedge clk);
        chk("rst i2s", {28'd0, b1.mclk, b1.sck, b1.lrck, b1.sdout}, 32'h0);
        chk("rst led/phase/s", {8'd0, led1, ph1, s1}, 32'h0);
        chk("rst phase3", {24'd0, ph3}, 32'h0);
        rst = 1'b1;
        n = 0;
        frame(l1, r1, l64, bad, lr);
        chk("f0 clkgen/sdout stable", bad, 0);
        chk("f0 lrck first rise", lr, 512);
        chk("f0 left", l1, 32'h40000000);
        chk("f0 right", r1, 32'h40000000);
        chk("f0 phase/s/led", {8'd0, ph1, s1, led1}, 32'h00010202);
        chk("f0 phase3", {24'd0, ph3}, 32'd3);
        chk("f0 inc64 phase/s", {16'd0, ph64, s64}, 32'h4080);
        chk("f0 inc85 phase/s", {16'd0, ph85, s85}, 32'h55AA);
        frame(l1, r1, l64, bad, lr);
        chk("f1 clkgen/sdout stable", bad, 0);
        chk("f1 left 0x82", l1, 32'h41000000);
        chk("f1 right 0x82", r1, 32'h41000000);
        chk("f1 inc64 word s=128", l64, 32'h0);
        chk("f1 phase/s", {16'd0, ph1, s1}, 32'h0204);
        chk("f1 phase3", {24'd0, ph3}, 32'd6);
        chk("f1 inc64 phase/s", {16'd0, ph64, s64}, 32'h80FF);
        chk("f1 inc85 phase/s", {16'd0, ph85, s85}, 32'hAAAB);
        frame(l1, r1, l64, bad, lr);
        chk("f2 inc64 word s=255", l64, 32'h3F800000);
        chk("f2 phase3", {24'd0, ph3}, 32'd9);
        chk("f2 inc64 phase/s", {16'd0, ph64, s64}, 32'hC07F);
        chk("f2 inc85 phase/s", {16'd0, ph85, s85}, 32'hFF01);
        frame(l1, r1, l64, bad, lr);
        chk("f3 left 0x86", l1, 32'h43000000);
        chk("f3 inc64 wrap", {16'd0, ph64, s64}, 32'h0000);
        chk("f3 inc85 wrap", {16'd0, ph85, s85}, 32'h54A8);
        repeat (700) @(negedge clk);
        n += 700;
        chk("pre-drop state", {24'd0, b1.sck, b1.lrck, ph1[5:0]}, 32'hC4);
        #2 rst = 1'b0;
        #1;
        chk("async drop i2s", {28'd0, b1.mclk, b1.sck, b1.lrck, b1.sdout}, 32'h0);
        chk("async drop led/phase/s", {8'd0, led1, ph1, s1}, 32'h0);
        repeat (2) @(negedge clk);
        chk("held rst", {24'd0, b1.sck, b1.lrck, ph3[5:0]}, 32'h0);
        rst = 1'b1;
        n = 0;
        frame(l1, r1, l64, bad, lr);
        chk("rerun clkgen/sdout stable", bad, 0);
        chk("rerun lrck first rise", lr, 512);
        chk("rerun left", l1, 32'h40000000);
        chk("rerun phase/s/led", {8'd0, ph1, s1, led1}, 32'h00010202);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
